// File: rtl/unidad_mul_div_pkg.sv
// Shared types, constants and opcode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] DIV0_Q = '1;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_div(input op_t op);
    return (op == F3_DIV) || (op == F3_DIVU) || (op == F3_REM) || (op == F3_REMU);
  endfunction

  function automatic logic is_rem(input op_t op);
    return (op == F3_REM) || (op == F3_REMU);
  endfunction

  // MUL is sign-agnostic in its low word, so it is treated as unsigned.
  function automatic logic is_signed_a(input op_t op);
    return (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
  endfunction

  function automatic logic is_signed_b(input op_t op);
    return (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
  endfunction

endpackage

// File: rtl/unidad_mul_div_if.sv
// Request/response bundle between control/register unit (master) and the mul/div unit (slave).
interface unidad_mul_div_if;
  import muldiv_pkg::*;

  logic             Start;
  logic [2:0]       Funct3;
  logic [WIDTH-1:0] RFrs1;
  logic [WIDTH-1:0] RFrs2;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;

  modport master (output Start, Funct3, RFrs1, RFrs2, input Busy, Done, Result);
  modport slave  (input Start, Funct3, RFrs1, RFrs2, output Busy, Done, Result);

endinterface

// File: rtl/unidad_mul_div_nucleo_divisor.sv
// One combinational restoring-division step on unsigned magnitudes.
module nucleo_divisor
  import muldiv_pkg::*;
(
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The remainder stays below the divisor, so a successful trial difference fits in WIDTH bits.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    fits    = (shifted >= {1'b0, divisor_i});
    diff    = shifted[WIDTH-1:0] - divisor_i;
    rem_o   = fits ? diff : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/unidad_mul_div.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish on the accept edge.
module unidad_mul_div
  import muldiv_pkg::*;
#(
  parameter int WIDTH = muldiv_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  unidad_mul_div_if.slave    bus
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  op_t              op_q;
  logic             sa_q, sb_q, sp_q;
  logic [WIDTH-1:0] opnd_q, hi_q, lo_q, sp_res_q;

  op_t              op_d;
  logic             sa_d, sb_d, div0_d, ovf_d, sp_d;
  logic [WIDTH-1:0] abs_a_d, abs_b_d, sp_res_d;
  logic             accept;

  // Operand decode, only meaningful on the accept edge.
  always_comb begin
    op_d    = op_t'(bus.Funct3);
    sa_d    = is_signed_a(op_d) & bus.RFrs1[WIDTH-1];
    sb_d    = is_signed_b(op_d) & bus.RFrs2[WIDTH-1];
    abs_a_d = sa_d ? -bus.RFrs1 : bus.RFrs1;
    abs_b_d = sb_d ? -bus.RFrs2 : bus.RFrs2;
    div0_d  = is_div(op_d) && (bus.RFrs2 == '0);
    ovf_d   = is_div(op_d) && is_signed_b(op_d) && (bus.RFrs1 == MIN_NEG) && (bus.RFrs2 == '1);
    sp_d    = div0_d | ovf_d;
    if (is_rem(op_d)) sp_res_d = div0_d ? bus.RFrs1 : '0;
    else              sp_res_d = div0_d ? DIV0_Q : bus.RFrs1;
  end

  assign accept = bus.Start && ((state_q == IDLE) || (state_q == DONE));

  logic [WIDTH:0]     msum;
  logic [WIDTH-1:0]   drem, dquo, nhi_d, nlo_d;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fin_d;
  logic               last;

  nucleo_divisor u_nucleo_divisor (
    .rem_i     (hi_q),
    .quo_i     (lo_q),
    .divisor_i (opnd_q),
    .rem_o     (drem),
    .quo_o     (dquo)
  );

  // hi:lo is the product register for multiply and remainder:quotient for divide.
  always_comb begin
    msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    if (is_div(op_q)) begin
      nhi_d = drem;
      nlo_d = dquo;
    end else begin
      nhi_d = msum[WIDTH:1];
      nlo_d = {msum[0], lo_q[WIDTH-1:1]};
    end
    prod   = {nhi_d, nlo_d};
    prod_s = (sa_q ^ sb_q) ? -prod : prod;
    quo_s  = (sa_q ^ sb_q) ? -nlo_d : nlo_d;
    rem_s  = sa_q ? -nhi_d : nhi_d;
    fin_d  = '0;
    unique case (op_q)
      F3_MUL:                        fin_d = prod_s[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fin_d = prod_s[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:               fin_d = quo_s;
      F3_REM, F3_REMU:               fin_d = rem_s;
      default:                       fin_d = '0;
    endcase
    if (sp_q) fin_d = sp_res_q;
  end

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // Datapath registers: loaded on accept, iterated in CALC; no reset needed.
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sp_q     <= sp_d;
      sp_res_q <= sp_res_d;
      hi_q     <= '0;
      opnd_q   <= is_div(op_d) ? abs_b_d : abs_a_d;
      lo_q     <= is_div(op_d) ? abs_a_d : abs_b_d;
    end else if (state_q == CALC) begin
      hi_q <= nhi_d;
      lo_q <= nlo_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            cnt_q <= '0;
            if (EARLY_OUT && sp_d) begin
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= sp_res_d;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= fin_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Result = result_q;

endmodule

// File: tb/tb_unidad_mul_div.sv
// Scoreboard bench for unidad_mul_div: directed RV32M vectors, timing, ignore-while-busy and abort.
module tb_unidad_mul_div;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SP_LAT = 0;
`else
  localparam int SP_LAT = 32;
`endif
  localparam int LAT = 32;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  unidad_mul_div_if bus();

  unidad_mul_div dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every Done must match the oldest expectation in value and cycle.
  always @(negedge clk) begin
    if (bus.Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_done: Done at cycle %0d with Result=%h, none expected", cyc, bus.Result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.Result !== e.res) begin
          n_fail++;
          $display("FAIL %s result: got %h expected %h", e.name, bus.Result, e.res);
        end
        n_cmp++;
        if (cyc != e.cyc) begin
          n_fail++;
          $display("FAIL %s done_cycle: got %0d expected %0d", e.name, cyc, e.cyc);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic issue(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat);
    exp_t e;
    bus.Start  = 1'b1;
    bus.Funct3 = f3;
    bus.RFrs1  = a;
    bus.RFrs2  = b;
    e.res  = res;
    e.cyc  = cyc + 1 + lat;
    e.name = nm;
    exp_q.push_back(e);
    @(negedge clk);
    bus.Start  = 1'b0;
    bus.Funct3 = 3'($urandom);
    bus.RFrs1  = $urandom;
    bus.RFrs2  = $urandom;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string nm, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] res, input int lat);
    issue(nm, f3, a, b, res, lat);
    drain(60);
  endtask

  initial begin
    int d1;
    bus.Start  = 1'b0;
    bus.Funct3 = '0;
    bus.RFrs1  = '0;
    bus.RFrs2  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy",   {31'b0, bus.Busy}, 32'h0);
    check("reset_done",   {31'b0, bus.Done}, 32'h0);
    check("reset_result", bus.Result,        32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue("mul_7x-3", F3_MUL, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
    for (int k = 0; k <= 32; k++) begin
      check($sformatf("mul_busy_k%0d", k), {31'b0, bus.Busy}, (k < 32) ? 32'h1 : 32'h0);
      @(negedge clk);
    end
    drain(10);

    run("mulh_min_sq",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT);
    run("mulhu_max_sq",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
    run("mulhsu_m1",     F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
    run("mulh_-7x3",     F3_MULH,   32'hFFFF_FFF9, 32'h3,         32'hFFFF_FFFF, LAT);
    run("mulhu_64k",     F3_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, LAT);
    run("mul_64k",       F3_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, LAT);
    run("div_-7/2",      F3_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, LAT);
    run("rem_-7/2",      F3_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, LAT);
    run("divu_100/7",    F3_DIVU,   32'd100,       32'd7,         32'd14,        LAT);
    run("remu_100/7",    F3_REMU,   32'd100,       32'd7,         32'd2,         LAT);
    run("div_20/-3",     F3_DIV,    32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, LAT);
    run("rem_20/-3",     F3_REM,    32'd20,        32'hFFFF_FFFD, 32'd2,         LAT);
    run("rem_-20/-3",    F3_REM,    32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, LAT);
    run("divu_max/2",    F3_DIVU,   32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, LAT);

    issue("div_5/0", F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SP_LAT);
    check("div0_busy", {31'b0, bus.Busy}, (SP_LAT != 0) ? 32'h1 : 32'h0);
    drain(60);
    run("rem_5/0",       F3_REM,    32'd5,         32'd0,         32'd5,         SP_LAT);
    run("div_-5/0",      F3_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, SP_LAT);
    run("rem_-5/0",      F3_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, SP_LAT);
    run("divu_5/0",      F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, SP_LAT);
    run("remu_5/0",      F3_REMU,   32'd5,         32'd0,         32'd5,         SP_LAT);
    run("div_ovf",       F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SP_LAT);
    run("rem_ovf",       F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SP_LAT);

    // A Start with new operands during CALC must be ignored.
    issue("mul_6x7_busy_start", F3_MUL, 32'd6, 32'd7, 32'd42, LAT);
    repeat (4) @(negedge clk);
    bus.Start  = 1'b1;
    bus.Funct3 = F3_MUL;
    bus.RFrs1  = 32'd100;
    bus.RFrs2  = 32'd100;
    @(negedge clk);
    bus.Start  = 1'b0;
    drain(60);

    // Start held in the Done cycle is accepted; second Done 33 cycles after the first.
    issue("divu_b2b_first", F3_DIVU, 32'd100, 32'd7, 32'd14, LAT);
    d1 = cyc + LAT;
    while (cyc < d1) @(negedge clk);
    issue("mul_b2b_second", F3_MUL, 32'd3, 32'd4, 32'd12, LAT);
    drain(60);

    // Asynchronous abort mid-CALC.
    issue("mulhu_aborted", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy",   {31'b0, bus.Busy}, 32'h0);
    check("abort_done",   {31'b0, bus.Done}, 32'h0);
    check("abort_result", bus.Result,        32'h0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run("remu_after_abort", F3_REMU, 32'd100, 32'd7, 32'd2, LAT);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
